// File: rtl/img_out_reader_if.sv
// Bus bundle for img_out_reader: the output-memory read port and the
// valid/ready pixel stream with last marker.
// master: the readback engine (drives address and stream).
// slave:  the memory plus downstream consumer (drive read data and ready).
interface img_out_reader_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output mem_raddr,
        input  mem_rdata,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  mem_raddr,
        output mem_rdata,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/img_out_reader.sv
// img_out_reader: walks the output-image memory from address 0 to
// out_w*out_h-1 after a start pulse, hides the 1-cycle registered read
// latency and streams the pixels out with valid/ready and a last marker.
// A 2-entry output FIFO plus credit-based read issue means no pixel is ever
// dropped under backpressure while keeping 1 pixel/cycle when m_ready=1.
// Optional feature macro: READBACK_CHECKSUM_EN adds the 16-bit csum output
// (running mod-2^16 sum of transferred pixels).
module img_out_reader #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,      // active-high asynchronous reset
    input  logic        start,
    input  logic [15:0] out_w,
    input  logic [15:0] out_h,
    output logic        busy,
    output logic        done,
    img_out_reader_if.master bus
`ifdef READBACK_CHECKSUM_EN
    ,
    output logic [15:0] csum
`endif
);

    localparam int CW = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Pixel count for the requested image, saturated to the memory size.
    function automatic logic [CW-1:0] clamp_total(input logic [15:0] w,
                                                  input logic [15:0] h);
        logic [31:0] prod;
        logic [32:0] limit;
        prod  = 32'(w) * 32'(h);
        limit = 33'(1) << ADDR_W;
        if ({1'b0, prod} > limit)
            return CW'(limit);
        else
            return CW'(prod);
    endfunction

    // Checksum accumulate, wrapping at 16 bits.
    function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                             input logic [DATA_W-1:0] d);
        return acc + 16'(d);
    endfunction

    logic [1:0]        state;
    logic [CW-1:0]     total_q;
    logic [CW-1:0]     issue_cnt;
    logic [ADDR_W-1:0] raddr;

    logic              rd_vld_p1;
    logic              rd_last_p1;

    logic [DATA_W-1:0] fifo_data [0:1];
    logic              fifo_last [0:1];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        fifo_count;

    logic [CW-1:0]     total_next;
    logic [2:0]        occ_next;
    logic              start_ok;
    logic              push;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              head_valid;
    logic              head_last;

    assign total_next = clamp_total(out_w, out_h);
    assign start_ok   = (state == S_IDLE) && start;
    assign head_valid = (fifo_count != 2'd0);
    assign head_last  = head_valid && fifo_last[rd_ptr];
    assign pop        = head_valid && bus.m_ready;
    assign push       = rd_vld_p1;

    // Occupancy the FIFO will hold after this edge from entries already
    // stored or in flight; a new read may only issue if that leaves a slot
    // free for it when it lands one edge later.
    assign occ_next   = 3'(fifo_count) + 3'(rd_vld_p1) - 3'(pop);
    assign issue      = (state == S_RUN) && (occ_next <= 3'd1);
    assign issue_last = issue && (issue_cnt == (total_q - CNT_ONE));

    assign bus.mem_raddr = raddr;
    assign bus.m_valid   = head_valid;
    assign bus.m_data    = head_valid ? fifo_data[rd_ptr] : '0;
    assign bus.m_last    = head_last;

    // Control FSM: start acceptance, read address walk, completion.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            total_q   <= '0;
            issue_cnt <= '0;
            raddr     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        total_q   <= total_next;
                        issue_cnt <= '0;
                        raddr     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= (total_next == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                        // Address holds on the final pixel so it never wraps.
                        if (issue_last)
                            state <= S_DRAIN;
                        else
                            raddr <= raddr + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (pop && head_last)
                        state <= S_FIN;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- stage p1: read issued, memory data arrives next edge ----
    // Track the outstanding read and whether it is the image's final pixel.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1  <= issue;
            rd_last_p1 <= issue_last;
        end
    end

    // ---- stage p2: memory data captured into the output FIFO ----
    // FIFO pointers and fill level.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    // FIFO storage; contents are qualified by the fill level, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rdata;
            fifo_last[wr_ptr] <= rd_last_p1;
        end
    end

`ifdef READBACK_CHECKSUM_EN
    // Running sum of every transferred pixel, restarted on accepted start.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            csum <= 16'd0;
        else if (start_ok)
            csum <= 16'd0;
        else if (pop)
            csum <= csum_add(csum, bus.m_data);
    end
`endif

endmodule

// File: tb/tb_img_out_reader.sv
// Testbench for img_out_reader. Uses ADDR_W=10 so the clamping case
// (1024x1024 request) completes quickly. A negedge monitor pops the expected
// pixel queue on every transfer; scenario tasks push expectations and check
// control timing.
module tb_img_out_reader;

    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int MEM = 1 << AW;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] out_w;
    logic [15:0] out_h;
    logic        busy;
    logic        done;
`ifdef READBACK_CHECKSUM_EN
    logic [15:0] csum;
`endif

    img_out_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    img_out_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .out_w (out_w),
        .out_h (out_h),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
`ifdef READBACK_CHECKSUM_EN
        ,
        .csum  (csum)
`endif
    );

    logic [7:0] mem [0:MEM-1];
    logic [8:0] exp_q [$];   // {last, data}

    int checks   = 0;
    int errors   = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;        // 0: always ready, 1: fixed pattern, 2: random

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic       prev_last  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory model.
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr];

    // Downstream ready generator.
    initial begin
        logic [5:0] pat;
        int         cyc;
        pat = 6'b101001;     // 1,0,0,1,0,1 in time order (bit 0 first)
        cyc = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)
                bus.m_ready = 1'b1;
            else if (rdy_mode == 1)
                bus.m_ready = pat[cyc % 6];
            else
                bus.m_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
    end

    // Scoreboard: compare each transfer against the expected queue and
    // check the stream holds still while stalled.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%02h last=%b, required valid=1 data=%02h last=%b",
                             bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer: data=%02h last=%b, required no transfer",
                             bus.m_data, bus.m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e[7:0] || bus.m_last !== e[8]) begin
                        errors++;
                        $display("FAIL pixel: data=%02h last=%b, required data=%02h last=%b",
                                 bus.m_data, bus.m_last, e[7:0], e[8]);
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    task automatic fill_mem_index();
        for (int i = 0; i < MEM; i++) mem[i] = 8'(i);
    endtask

    task automatic push_expect(input int w, input int h);
        int total;
        total = w * h;
        if (total > MEM) total = MEM;
        for (int i = 0; i < total; i++)
            exp_q.push_back({(i == total - 1), mem[i]});
    endtask

    // Pulse start so the DUT samples it on the next rising edge.
    task automatic pulse_start(input int w, input int h);
        @(posedge clk); #1;
        out_w = 16'(w);
        out_h = 16'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        out_w = 16'd0;
        out_h = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
            bus.m_data !== 8'h00 || bus.mem_raddr !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b last=%b data=%02h raddr=%0d, required all 0",
                     busy, done, bus.m_valid, bus.m_last, bus.m_data, bus.mem_raddr);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_basic();
        int base;
        fill_mem_index();
        rdy_mode = 0;
        base = xfer_cnt;
        push_expect(4, 4);
        @(posedge clk); #1;
        out_w = 16'd4; out_h = 16'd4; start = 1'b1;
        @(posedge clk); #1;            // edge N
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.mem_raddr !== 10'd0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_start: busy=%b raddr=%0d valid=%b, required 1 0 0",
                     busy, bus.mem_raddr, bus.m_valid);
        end
        @(posedge clk); #1;            // N+1
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_n1: valid=%b, required 0", bus.m_valid);
        end
        @(posedge clk); #1;            // N+2
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h00 || bus.m_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_valid: valid=%b data=%02h last=%b, required 1 00 0",
                     bus.m_valid, bus.m_data, bus.m_last);
        end
        repeat (16) @(posedge clk);    // N+18: final transfer edge
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_n18: busy=%b done=%b, required 1 0", busy, done);
        end
        @(posedge clk); #1;            // N+19
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_n19: busy=%b done=%b valid=%b, required 0 1 0", busy, done, bus.m_valid);
        end
        checks++;
        if (xfer_cnt - base != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: transfers=%0d left=%0d, required 16 0", xfer_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int base;
        fill_mem_index();
        rdy_mode = 1;
        base = xfer_cnt;
        push_expect(4, 4);
        pulse_start(4, 4);
        wait_done("bp", 200);
        checks++;
        if (xfer_cnt - base != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: transfers=%0d left=%0d, required 16 0", xfer_cnt - base, exp_q.size());
        end
        rdy_mode = 0;
    endtask

    task automatic test_zero();
        int base;
        base = xfer_cnt;
        @(posedge clk); #1;
        out_w = 16'd0; out_h = 16'd7; start = 1'b1;
        @(posedge clk); #1;            // edge N
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_n: busy=%b done=%b valid=%b, required 1 0 0", busy, done, bus.m_valid);
        end
        @(posedge clk); #1;            // N+1
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || bus.mem_raddr !== 10'd0) begin
            errors++;
            $display("FAIL zero_n1: busy=%b done=%b raddr=%0d, required 0 1 0", busy, done, bus.mem_raddr);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (xfer_cnt != base || bus.m_valid !== 1'b0 || bus.mem_raddr !== 10'd0) begin
            errors++;
            $display("FAIL zero_quiet: transfers=%0d valid=%b raddr=%0d, required 0 0 0",
                     xfer_cnt - base, bus.m_valid, bus.mem_raddr);
        end
    endtask

    task automatic test_restart_and_abort();
        int base;
        int i;
        fill_mem_index();
        rdy_mode = 2;
        base = xfer_cnt;
        push_expect(8, 8);
        pulse_start(8, 8);
        i = 0;
        while (xfer_cnt - base < 10 && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (xfer_cnt - base < 10) begin
            errors++;
            $display("FAIL restart_reach10: transfers=%0d, required 10", xfer_cnt - base);
        end
        out_w = 16'd2; out_h = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart", 500);
        checks++;
        if (xfer_cnt - base != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_count: transfers=%0d left=%0d, required 64 0", xfer_cnt - base, exp_q.size());
        end

        base = xfer_cnt;
        push_expect(8, 8);
        pulse_start(8, 8);
        i = 0;
        while (xfer_cnt - base < 5 && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
            bus.m_data !== 8'h00 || bus.mem_raddr !== 10'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b valid=%b last=%b data=%02h raddr=%0d, required all 0",
                     busy, done, bus.m_valid, bus.m_last, bus.m_data, bus.mem_raddr);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rdy_mode = 0;
        base = xfer_cnt;
        push_expect(2, 2);
        pulse_start(2, 2);
        wait_done("after_abort", 100);
        checks++;
        if (xfer_cnt - base != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_abort_count: transfers=%0d left=%0d, required 4 0", xfer_cnt - base, exp_q.size());
        end
    endtask

`ifdef READBACK_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 16; k++) mem[k] = 8'(8'hF0 + k);
        rdy_mode = 1;
        push_expect(4, 4);
        pulse_start(4, 4);
        wait_done("csum", 200);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (csum !== 16'h0F78 || done !== 1'b1) begin
            errors++;
            $display("FAIL csum_4x4: csum=%04h done=%b, required 0f78 1", csum, done);
        end
        mem[0] = 8'h05;
        rdy_mode = 0;
        push_expect(1, 1);
        pulse_start(1, 1);
        wait_done("csum1", 50);
        checks++;
        if (csum !== 16'h0005) begin
            errors++;
            $display("FAIL csum_1x1: csum=%04h, required 0005", csum);
        end
    endtask
`endif

    task automatic test_clamp();
        int base;
        fill_mem_index();
        rdy_mode = 0;
        base = xfer_cnt;
        push_expect(1024, 1024);
        pulse_start(1024, 1024);
        wait_done("clamp", 3000);
        checks++;
        if (xfer_cnt - base != MEM || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clamp_count: transfers=%0d left=%0d, required %0d 0", xfer_cnt - base, exp_q.size(), MEM);
        end
        checks++;
        if (bus.mem_raddr !== 10'h3FF) begin
            errors++;
            $display("FAIL clamp_raddr: raddr=%03h, required 3ff", bus.mem_raddr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_restart_and_abort();
`ifdef READBACK_CHECKSUM_EN
        test_checksum();
`endif
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
